rv3n_jcond_sched: RTL
=====================

# rv3n_jcond_sched

Issue scheduler for the single conditional-branch/JALR resolution unit (`func_jcond`). It accepts branch requests from two in-order dispatch lanes, buffers them in an age-ordered queue, and issues at most one per cycle to the unit, oldest first. It discards all buffered, wrong-path branches when a redirect (typically `jump_jcond_valid`) is flagged, and honours the unit's busy signal.

## Interface
Parameters:
- `DEPTH`, 4: queue entries; power of two, ≥ 2.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in0_valid` / `in1_valid`  in  1  lane request valid; lane 0 is older than lane 1.
- `in0_ready` / `in1_ready`  out  1  lane request accepted this cycle when ready & valid.
- `in0_para` / `in1_para`  in  8  branch parameters: [2:0] condition, [6] jalr, [7] predicted-taken.
- `in0_imm` / `in1_imm`  in  13  branch offset.
- `in0_pc` / `in1_pc`  in  `XLEN`  branch PC.
- `in0_op0` / `in0_op1` / `in1_op0` / `in1_op1`  in  `XLEN`  source operands.
- `sched_flush`  in  1  redirect; kills all queued and inbound requests.
- `func_jcond_ack_busy`  in  1  unit cannot accept an issue this cycle.
- `func_jcond_req_valid`  out  1  issue strobe.
- `func_jcond_req_para`, `_imm`, `_pc`, `_operand0`, `_operand1`  out  8/13/`XLEN`/`XLEN`/`XLEN`  issued payload.
- `sched_count`  out  $clog2(DEPTH)+1  occupied entries.
- `sched_empty`  out  1  `sched_count == 0`.

## Operation
- Circular FIFO with read pointer, write pointer, and count. Entry = {para, imm, pc, op0, op1}.
- Readiness is computed from the registered count only; same-cycle dequeues are not credited:
  - `in0_ready = ~sched_flush & (count < DEPTH)`.
  - `in1_ready = ~sched_flush & (in0_valid ? (in0_ready & count ≤ DEPTH-2) : count < DEPTH)`.
- Lane 1 is never accepted while a valid lane 0 is refused, which preserves age order.
- Enqueue order per cycle: lane 0 first, then lane 1. The write pointer advances by the number accepted.
- Issue: `req_valid = (count != 0) & ~func_jcond_ack_busy & ~sched_flush`. The payload is the head entry. On issue, the read pointer advances.
- Next count = count + accepted − issued.
- While `req_valid` is low, all payload outputs are driven to 0.
- Flush: the next count is 0 and the read pointer equals the write pointer. Issue is suppressed combinationally in the flush cycle. Inbound requests are not accepted.
- Busy: the head is held unchanged, with no pointer movement, for as long as busy stays high.
- Pointer wrap: modulo DEPTH.

## Timing
- After reset:
  - count 0, pointers 0, `sched_empty` 1.
  - `in0_ready` / `in1_ready` 1 (absent flush).
  - `req_valid` 0, payload 0.
  - Entry storage is cleared to 0.
- Reset dominates flush and valid.
- Latency without bypass: a request accepted at cycle T issues no earlier than T+1.
- Throughput: one issue per cycle; two enqueues per cycle.
- `sched_flush` → `req_valid` is a combinational path; `sched_flush` must come from a register (`jump_jcond_valid` does).
- Enqueue when count = DEPTH−1 with both lanes valid: lane 0 only is accepted.
- Simultaneous issue and two enqueues at count = DEPTH−2: both lanes are accepted and the count becomes DEPTH−1.

## Configuration
- `JCOND_SCHED_BYPASS_EN` defined:
  - When count = 0, `~busy`, `~flush` and `in0_valid`, lane 0 is issued in the same cycle directly from the lane inputs, and it is not written to the queue.
  - Lane 1 (if valid and ready) is enqueued into the head slot, and count becomes 1.
  - `in0_ready` is unaffected.
- Undefined: all requests pass through the queue, with a minimum latency of 1 cycle.

## Test plan
- Reset: hold `rst` 2 cycles with lanes valid → `sched_count`=0, `req_valid`=0, both ready=1, payload 0.
- Single request: `in0` pc=0x100, para=0x01, at cycle T → `req_valid`=1 with pc=0x100 at T+1 (at T with `JCOND_SCHED_BYPASS_EN`); count returns to 0.
- Dual lane: `in0` pc=0x200, `in1` pc=0x204 same cycle → issues 0x200 then 0x204 in consecutive cycles; never reversed.
- Full/backpressure: DEPTH=4, busy=1, push 0x300..0x30C → count=4, `in0_ready`=0. At count=3 with both lanes valid, only lane 0 is accepted. Release busy → four issues in order, one per cycle.
- Flush: 3 entries queued, pulse `sched_flush` with `in0_valid`=1 → `req_valid`=0 that cycle, lane 0 not accepted, count=0 next cycle, no stale issue afterwards.
- Busy hold: head pc=0x400, busy high 3 cycles → `req_valid`=0, count unchanged; busy low → 0x400 issued next.

Source files
------------

// File: rtl/rv3n_jcond_sched.sv
// rv3n_jcond_sched
//
// Issue scheduler for the single conditional-branch/JALR resolution unit (func_jcond).
// Two in-order dispatch lanes (lane 0 older) enqueue into an age-ordered circular queue.
// At most one entry issues per cycle, oldest first. A redirect (sched_flush) discards every
// queued and inbound request, and the unit's busy signal holds the head in place.
//
// Optional feature: define JCOND_SCHED_BYPASS_EN so that lane 0 can issue straight from its
// inputs in the same cycle when the queue is empty.
//
// Parameters:
//   DEPTH  queue entries (power of two, >= 2)
//   XLEN   PC / operand width
//
// Ports:
//   clk, rst                           clock, synchronous active-high reset
//   in{0,1}_valid / in{0,1}_ready      lane handshakes
//   in{0,1}_para/_imm/_pc/_op0/_op1    lane payloads
//   sched_flush                        redirect, kills queued and inbound requests
//   func_jcond_ack_busy                unit cannot take an issue this cycle
//   func_jcond_req_valid               issue strobe
//   func_jcond_req_para/_imm/_pc/_operand0/_operand1   issued payload (0 when not issuing)
//   sched_count, sched_empty           occupancy
module rv3n_jcond_sched #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic                     in0_valid,
    output logic                     in0_ready,
    input  logic [7:0]               in0_para,
    input  logic [12:0]              in0_imm,
    input  logic [XLEN-1:0]          in0_pc,
    input  logic [XLEN-1:0]          in0_op0,
    input  logic [XLEN-1:0]          in0_op1,

    input  logic                     in1_valid,
    output logic                     in1_ready,
    input  logic [7:0]               in1_para,
    input  logic [12:0]              in1_imm,
    input  logic [XLEN-1:0]          in1_pc,
    input  logic [XLEN-1:0]          in1_op0,
    input  logic [XLEN-1:0]          in1_op1,

    input  logic                     sched_flush,
    input  logic                     func_jcond_ack_busy,

    output logic                     func_jcond_req_valid,
    output logic [7:0]               func_jcond_req_para,
    output logic [12:0]              func_jcond_req_imm,
    output logic [XLEN-1:0]          func_jcond_req_pc,
    output logic [XLEN-1:0]          func_jcond_req_operand0,
    output logic [XLEN-1:0]          func_jcond_req_operand1,

    output logic [$clog2(DEPTH):0]   sched_count,
    output logic                     sched_empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] LP_DEPTH    = CW'(DEPTH);
    localparam logic [CW-1:0] LP_DEPTH_M2 = CW'(DEPTH - 2);

    // Queue storage
    logic [7:0]      r_para [DEPTH];
    logic [12:0]     r_imm  [DEPTH];
    logic [XLEN-1:0] r_pc   [DEPTH];
    logic [XLEN-1:0] r_op0  [DEPTH];
    logic [XLEN-1:0] r_op1  [DEPTH];

    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;

    logic            w_acc0;
    logic            w_acc1;
    logic            w_q_issue;
    logic            w_bypass;
    logic            w_wr0;
    logic [PW-1:0]   w_wr_ptr1;

    // Readiness uses only the registered count; a same-cycle dequeue is not credited.
    assign in0_ready = ~sched_flush & (r_count < LP_DEPTH);
    assign in1_ready = ~sched_flush &
                       (in0_valid ? (in0_ready & (r_count <= LP_DEPTH_M2))
                                  : (r_count < LP_DEPTH));

    assign w_acc0 = in0_valid & in0_ready;
    assign w_acc1 = in1_valid & in1_ready;

    assign w_q_issue = (r_count != '0) & ~func_jcond_ack_busy & ~sched_flush;

`ifdef JCOND_SCHED_BYPASS_EN
    // Empty queue: lane 0 goes straight to the unit and never occupies a slot.
    assign w_bypass = (r_count == '0) & ~func_jcond_ack_busy & ~sched_flush & in0_valid & ~rst;
`else
    assign w_bypass = 1'b0;
`endif

    // Lane 0 takes the tail slot unless bypassed; lane 1 lands right after whatever lane 0 used.
    assign w_wr0     = w_acc0 & ~w_bypass;
    assign w_wr_ptr1 = r_wr_ptr + PW'(w_wr0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_para[i] <= '0;
                r_imm[i]  <= '0;
                r_pc[i]   <= '0;
                r_op0[i]  <= '0;
                r_op1[i]  <= '0;
            end
        end else if (sched_flush) begin
            // Nothing is accepted during flush, so the write pointer stays put.
            r_count  <= '0;
            r_rd_ptr <= r_wr_ptr;
        end else begin
            if (w_wr0) begin
                r_para[r_wr_ptr] <= in0_para;
                r_imm[r_wr_ptr]  <= in0_imm;
                r_pc[r_wr_ptr]   <= in0_pc;
                r_op0[r_wr_ptr]  <= in0_op0;
                r_op1[r_wr_ptr]  <= in0_op1;
            end
            if (w_acc1) begin
                r_para[w_wr_ptr1] <= in1_para;
                r_imm[w_wr_ptr1]  <= in1_imm;
                r_pc[w_wr_ptr1]   <= in1_pc;
                r_op0[w_wr_ptr1]  <= in1_op0;
                r_op1[w_wr_ptr1]  <= in1_op1;
            end
            r_wr_ptr <= w_wr_ptr1 + PW'(w_acc1);
            r_rd_ptr <= r_rd_ptr + PW'(w_q_issue);
            r_count  <= r_count + CW'(w_wr0) + CW'(w_acc1) - CW'(w_q_issue);
        end
    end

    // Issue payload; zero whenever nothing is issued.
    always_comb begin
        func_jcond_req_valid    = 1'b0;
        func_jcond_req_para     = '0;
        func_jcond_req_imm      = '0;
        func_jcond_req_pc       = '0;
        func_jcond_req_operand0 = '0;
        func_jcond_req_operand1 = '0;
        if (w_q_issue) begin
            func_jcond_req_valid    = 1'b1;
            func_jcond_req_para     = r_para[r_rd_ptr];
            func_jcond_req_imm      = r_imm[r_rd_ptr];
            func_jcond_req_pc       = r_pc[r_rd_ptr];
            func_jcond_req_operand0 = r_op0[r_rd_ptr];
            func_jcond_req_operand1 = r_op1[r_rd_ptr];
        end else if (w_bypass) begin
            func_jcond_req_valid    = 1'b1;
            func_jcond_req_para     = in0_para;
            func_jcond_req_imm      = in0_imm;
            func_jcond_req_pc       = in0_pc;
            func_jcond_req_operand0 = in0_op0;
            func_jcond_req_operand1 = in0_op1;
        end
    end

    assign sched_count = r_count;
    assign sched_empty = (r_count == '0);

endmodule
